shift_register_4bits_serial_in: RTL and testbench

- Serial-in, parallel-out deserializer; the receive-side counterpart of the team's 4-bit parallel-load, MSB-first serial shifter.
- Accepts one bit per enabled clock, MSB first, and assembles WIDTH-bit words.
- Presents each completed word in an output holding register with a valid/ready handshake, plus a complement output.
- Sits between a serial link and parallel consumer logic.

---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_bit_counter.sv | 31 +++
 rtl/shift_register_4bits_serial_in.sv | 127 ++++++++++++
 tb/tb_shift_register_4bits_serial_in.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out deserializer:
// frame states, counter width helper and reset values.
package sipo_pkg;

   // Frame position when the parity option is built in.
   typedef enum logic {
      DATA   = 1'b0,
      PARITY = 1'b1
   } state_t;

   localparam logic RST_VALID   = 1'b0;
   localparam logic RST_OVERRUN = 1'b0;
   localparam logic RST_PERR    = 1'b0;

   // Bits needed to count 0..w-1.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter for the deserializer.
// Ports: clk, rst (sync, active high), en (count), clr (restart at 0),
//        last_bit (count is at WIDTH-1).
import sipo_pkg::*;

module sipo_bit_counter #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic last_bit
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt;

   assign last_bit = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last_bit ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/shift_register_4bits_serial_in.sv
// Serial-in, parallel-out deserializer, MSB first, with valid/ready output.
// Ports: clk, rst (sync, active high), sin, sin_en, sync (frame resync),
//        out_ready; outputs Q, Qbar (~Q), out_valid, overrun (drop pulse).
// Option SIPO_PARITY_EN: trailing even-parity bit per word and parity_err.
import sipo_pkg::*;

module shift_register_4bits_serial_in #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sync,
   input  logic             out_ready,
`ifdef SIPO_PARITY_EN
   output logic             parity_err,
`endif
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             out_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] word;
   logic             last;
   logic             shift_en;
   logic             complete;
   logic             transfer;
   logic             accept;

   assign transfer = out_valid && out_ready;
   assign accept   = !out_valid || out_ready;
   assign Qbar     = ~Q;

`ifdef SIPO_PARITY_EN
   state_t state;
   state_t state_nxt;
   logic   perr_new;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DATA;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         DATA: begin
            if (!sync && sin_en && last) begin
               state_nxt = PARITY;
            end
         end
         PARITY: begin
            if (sync || sin_en) begin
               state_nxt = DATA;
            end
         end
         default: state_nxt = DATA;
      endcase
   end

   // Data bits shift only in DATA; the parity bit just closes the frame.
   assign shift_en = sin_en && (state == DATA);
   assign complete = !sync && sin_en && (state == PARITY);
   assign word     = sr;
   assign perr_new = (^sr) ^ sin;
`else
   assign shift_en = sin_en;
   assign complete = !sync && sin_en && last;
   assign word     = {sr[WIDTH-2:0], sin};
`endif

   sipo_bit_counter #(
      .WIDTH(WIDTH)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (shift_en),
      .clr     (sync),
      .last_bit(last)
   );

   always_ff @(posedge clk) begin
      if (rst || sync) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= {sr[WIDTH-2:0], sin};
      end
   end

   // A completed word is kept only if the holding register is free
   // or being emptied on this same edge; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         Q         <= '0;
         out_valid <= RST_VALID;
         overrun   <= RST_OVERRUN;
`ifdef SIPO_PARITY_EN
         parity_err <= RST_PERR;
`endif
      end else begin
         overrun <= 1'b0;
         if (complete) begin
            if (accept) begin
               Q         <= word;
               out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
               parity_err <= perr_new;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (transfer) begin
            out_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_shift_register_4bits_serial_in.sv
// Randomised scoreboard bench for the serial-in deserializer.
// A bit-queue reference model predicts every cycle; a monitor checks transfers.
module tb_shift_register_4bits_serial_in;

   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME = W + PAR;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sin = 1'b0;
   logic         sin_en = 1'b0;
   logic         sync = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] Q;
   logic [W-1:0] Qbar;
   logic         out_valid;
   logic         overrun;
`ifdef SIPO_PARITY_EN
   logic         parity_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int bits[$];
   int sb[$];
   int mq = 0;
   int mv = 0;
   int movr = 0;
   int mperr = 0;

   always #5 clk = ~clk;

   shift_register_4bits_serial_in #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sin_en    (sin_en),
      .sync      (sync),
      .out_ready (out_ready),
`ifdef SIPO_PARITY_EN
      .parity_err(parity_err),
`endif
      .Q         (Q),
      .Qbar      (Qbar),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one clock edge, from the word-level rules.
   task automatic model_edge();
      int w;
      int ones;
      int done;
      int xfer;
      int perr;
      done = 0;
      perr = 0;
      w = 0;
      if (rst) begin
         bits.delete();
         sb.delete();
         mq = 0; mv = 0; movr = 0; mperr = 0;
         return;
      end
      movr = 0;
      xfer = mv && out_ready;
      if (sync) begin
         bits.delete();
      end else if (sin_en) begin
         bits.push_back(int'(sin));
         if (bits.size() == FRAME) begin
            ones = 0;
            for (int i = 0; i < W; i++) begin
               w = w * 2 + bits[i];
               ones += bits[i];
            end
            if (PAR == 1) perr = (ones + bits[W]) % 2;
            bits.delete();
            done = 1;
         end
      end
      if (done) begin
         if (!mv || out_ready) begin
            mq = w; mv = 1; mperr = perr;
            sb.push_back(w);
         end else begin
            movr = 1;
         end
      end else if (xfer) begin
         mv = 0; mperr = 0;
      end
   endtask

   task automatic check_outputs();
      chk("q", int'(Q), mq);
      chk("qbar", int'(Qbar), (~mq) & ((1 << W) - 1));
      chk("out_valid", int'(out_valid), mv);
      chk("overrun", int'(overrun), movr);
`ifdef SIPO_PARITY_EN
      chk("parity_err", int'(parity_err), mperr);
`endif
   endtask

   task automatic step(input logic r, input logic s, input logic e,
                       input logic y, input logic rd);
      rst = r; sin = s; sin_en = e; sync = y; out_ready = rd;
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic send(input int v, input int n, input logic rd_last);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b0, 1'(v >> i), 1'b1, 1'b0, (i == 0) ? rd_last : 1'b0);
      end
   endtask

   // Send a data word plus, when built in, its correct parity bit.
   task automatic send_word(input int v, input logic rd_last);
      if (PAR == 1) begin
         send(v, W, 1'b0);
         send($countones(v) % 2, 1, rd_last);
      end else begin
         send(v, W, rd_last);
      end
   endtask

   task automatic drain();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: a transfer at the coming edge must carry the oldest word.
   always @(negedge clk) begin
      int e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_empty_pop", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("transfer_q", int'(Q), e);
         end
      end
   end

   initial begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_qbar", int'(Qbar), 'hF);

      send_word('hB, 1'b0);
      chk("d1_q", int'(Q), 'hB);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("d1_hold", int'(Q), 'hB);
      drain();

      for (int i = 3; i >= 0; i--) begin
         step(1'b0, 1'(6 >> i), 1'b1, 1'b0, 1'b0);
         if (i != 0) step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
      end
      if (PAR == 1) send(0, 1, 1'b0);
      chk("d2_q", int'(Q), 'h6);
      drain();

      send_word('hA, 1'b0);
      send_word('h5, 1'b0);
      chk("d3_keep", int'(Q), 'hA);
      send_word('h5, 1'b1);
      chk("d3_replace", int'(Q), 'h5);
      chk("d3_valid", int'(out_valid), 1);
      drain();

      send(3, 2, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      send_word('h3, 1'b0);
      chk("d4_q", int'(Q), 'h3);
      drain();

      send(3, 2, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      send_word('h9, 1'b0);
      chk("d5_q", int'(Q), 'h9);
      drain();

`ifdef SIPO_PARITY_EN
      send('hB, W, 1'b0);
      send(1, 1, 1'b0);
      chk("p1_err", int'(parity_err), 0);
      drain();
      send('hB, W, 1'b0);
      send(0, 1, 1'b0);
      chk("p2_err", int'(parity_err), 1);
      chk("p2_q", int'(Q), 'hB);
      drain();
`endif

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(63) == 0), 1'($urandom_range(1)),
              ($urandom_range(2) != 0), ($urandom_range(23) == 0),
              ($urandom_range(2) == 0));
      end
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
